// File: rtl/pudding_loader_pkg.sv
// Shared types for the PUDDING DAC configuration-chain loader.
//   PUDDING_N       : chip daisychain length in bits
//   loader_state_t  : loader FSM states
//   pin_bundle_t    : the five chip control pins, registered as one unit
package pudding_pkg;

  localparam int unsigned PUDDING_N = 128;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SETUP,
    PULSE,
    COMMIT
  } loader_state_t;

  typedef struct packed {
    logic datum;
    logic shift;
    logic transfer;
    logic dir;
    logic stateen;
  } pin_bundle_t;

endpackage

// File: rtl/pudding_loader_if.sv
// Pattern-offer handshake between a pattern source and the loader.
//   s_valid  : pattern offered
//   s_ready  : loader idle and accepting
//   s_data   : N-bit DAC pattern, bit N-1 lands in chip state[N-1]
//   s_enable : stateen value applied on accept
interface pudding_loader_if
  import pudding_pkg::*;
#(
  parameter int unsigned N = PUDDING_N
) ();

  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_enable;

  modport master (output s_valid, output s_data, output s_enable, input s_ready);
  modport slave  (input s_valid, input s_data, input s_enable, output s_ready);

endinterface

// File: rtl/pudding_loader.sv
// Serial driver for the PUDDING DAC configuration chain. Shifts one accepted
// pattern MSB-first into the chip daisychain (two cycles per bit), then commits
// it to the chip state register with transfer=1, dir=1.
// Ports:
//   clk, rst_n      : clock shared with the chip, synchronous active-low reset
//   bus (slave)     : s_valid/s_ready/s_data/s_enable pattern handshake
//   busy            : transaction in progress
//   done            : one-cycle pulse in the commit cycle
//   pin_datum/shift/transfer/dir/stateen : registered chip control pins
//   pin_sdo         : chip daisychain[N-1], used only with readback
//   rb_data/rb_valid: previous chip state and its strobe (readback builds only)
// Optional feature: define PUDDING_READBACK_EN to capture the old chip state
// into the daisychain before shifting and return it on rb_data.
module pudding_loader
  import pudding_pkg::*;
#(
  parameter int unsigned N = PUDDING_N
) (
  input  logic             clk,
  input  logic             rst_n,
  pudding_loader_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             pin_datum,
  output logic             pin_shift,
  output logic             pin_transfer,
  output logic             pin_dir,
  output logic             pin_stateen,
  input  logic             pin_sdo
`ifdef PUDDING_READBACK_EN
  ,
  output logic [N-1:0]     rb_data,
  output logic             rb_valid
`endif
);

  localparam int unsigned CNT_W = $clog2(N);

  loader_state_t    state_q, state_d;
  logic [N-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pin_bundle_t      pins_q, pins_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PUDDING_READBACK_EN
  logic [N-1:0]     rb_q, rb_d;
  logic             rb_valid_q, rb_valid_d;
`else
  logic             sdo_unused;
  assign sdo_unused = pin_sdo;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pins_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PUDDING_READBACK_EN
      rb_q       <= '0;
      rb_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pins_q     <= pins_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PUDDING_READBACK_EN
      rb_q       <= rb_d;
      rb_valid_q <= rb_valid_d;
`endif
    end
  end

  // Next state, datapath and next pin values
  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    cnt_d           = cnt_q;
    pins_d          = pins_q;
    pins_d.shift    = 1'b0;
    pins_d.transfer = 1'b0;
    pins_d.dir      = 1'b0;
    done_d          = 1'b0;
`ifdef PUDDING_READBACK_EN
    rb_d            = rb_q;
    rb_valid_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.s_valid && ready_q) begin
          sr_d           = bus.s_data;
          cnt_d          = '0;
          pins_d.stateen = bus.s_enable;
`ifdef PUDDING_READBACK_EN
          state_d        = CAPTURE;
`else
          state_d        = SETUP;
`endif
        end
      end
      CAPTURE: state_d = SETUP;
      SETUP: begin
        state_d = PULSE;
`ifdef PUDDING_READBACK_EN
        // Chip chain MSB is stable during SETUP; collect old state MSB-first
        rb_d = {rb_q[N-2:0], pin_sdo};
`endif
      end
      PULSE: begin
        sr_d    = sr_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(N - 1)) ? COMMIT : SETUP;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered, so they are driven for the state being entered
    case (state_d)
      CAPTURE: pins_d.transfer = 1'b1;
      SETUP:   pins_d.datum    = sr_d[N-1];
      PULSE:   pins_d.shift    = 1'b1;
      COMMIT: begin
        pins_d.transfer = 1'b1;
        pins_d.dir      = 1'b1;
        done_d          = 1'b1;
`ifdef PUDDING_READBACK_EN
        rb_valid_d      = 1'b1;
`endif
      end
      default: ;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.s_ready  = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pin_datum    = pins_q.datum;
  assign pin_shift    = pins_q.shift;
  assign pin_transfer = pins_q.transfer;
  assign pin_dir      = pins_q.dir;
  assign pin_stateen  = pins_q.stateen;
`ifdef PUDDING_READBACK_EN
  assign rb_data      = rb_q;
  assign rb_valid     = rb_valid_q;
`endif

endmodule

// File: tb/tb_pudding_loader.sv
// Bench for pudding_loader: drives patterns through the handshake, models the
// PUDDING chip chain as the pin partner, and checks chip contents, latency,
// pin protocol, reset abort and stateen behaviour against expected values.
module tb_pudding_loader;
  import pudding_pkg::*;

  localparam int unsigned N = PUDDING_N;
`ifdef PUDDING_READBACK_EN
  localparam int unsigned LAT = 2 * N + 2;
`else
  localparam int unsigned LAT = 2 * N + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pudding_loader_if #(.N(N)) bus ();

  logic busy, done, pin_datum, pin_shift, pin_transfer, pin_dir, pin_stateen, pin_sdo;
`ifdef PUDDING_READBACK_EN
  logic [N-1:0] rb_data;
  logic         rb_valid;
`endif

  pudding_loader #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .pin_datum    (pin_datum),
    .pin_shift    (pin_shift),
    .pin_transfer (pin_transfer),
    .pin_dir      (pin_dir),
    .pin_stateen  (pin_stateen),
    .pin_sdo      (pin_sdo)
`ifdef PUDDING_READBACK_EN
    ,
    .rb_data      (rb_data),
    .rb_valid     (rb_valid)
`endif
  );

  // Chip partner: daisychain + state register, transfer has priority over shift
  logic [N-1:0] chain = '0;
  logic [N-1:0] cstate = '0;
  logic         preload_req = 1'b0;
  logic [N-1:0] preload_val = '0;
  logic [7:0]   uo_out;
  assign uo_out  = {chain[N-1], 7'd0};
  assign pin_sdo = uo_out[7];

  always @(posedge clk) begin
    if (preload_req) cstate <= preload_val;
    else if (pin_transfer) begin
      if (pin_dir) cstate <= chain;
      else         chain  <= cstate;
    end else if (pin_shift) chain <= {chain[N-2:0], pin_datum};
  end

  // Protocol monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_accepts = 0, n_done = 0, accept_cyc = 0, done_cyc = 0;
  int shift_cnt = 0, commit_cnt = 0, overlap_cnt = 0, last_shift_cyc = 0, commit_cyc = 0;
  int ready_low_cnt = 0, last_ready_low = 0, stateen_bad = 0, rb_mis = 0;
  logic prev_stateen = 1'b0, prev_acc = 1'b0, prev_rst = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pin_shift && pin_transfer) overlap_cnt++;
      if (pin_shift) begin shift_cnt++; last_shift_cyc = cyc; end
      if (pin_transfer && pin_dir) begin commit_cnt++; commit_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
`ifdef PUDDING_READBACK_EN
      if (rb_valid !== done) rb_mis++;
`endif
      if (prev_rst && !prev_acc && (pin_stateen !== prev_stateen)) stateen_bad++;
      if (!bus.s_ready) ready_low_cnt++;
      if (bus.s_valid && bus.s_ready) begin
        n_accepts++;
        accept_cyc     = cyc;
        last_ready_low = ready_low_cnt;
        ready_low_cnt  = 0;
        shift_cnt      = 0;
        commit_cnt     = 0;
        overlap_cnt    = 0;
      end
      prev_acc = bus.s_valid && bus.s_ready;
    end else prev_acc = 1'b0;
    prev_stateen = pin_stateen;
    prev_rst     = rst_n;
  end

  int n_tests = 0, n_fail = 0;
  logic [N-1:0] model_state = '0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_pat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_done(input int target, input int budget);
    int w = 0;
    while (n_done < target && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  // One full transaction from an idle loader, with all per-transaction checks
  task automatic run_txn(input logic [N-1:0] pat, input logic en, input string tag);
    int d0;
    logic [N-1:0] prev;
    prev = model_state;
    d0 = n_done;
    bus.s_data = pat; bus.s_enable = en; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_done(d0 + 1, LAT + 20);
    check({tag, "_done_cnt"}, N'(n_done - d0), N'(1));
    check({tag, "_latency"}, N'(done_cyc - accept_cyc), N'(LAT));
    check({tag, "_shifts"}, N'(shift_cnt), N'(N));
    check({tag, "_commits"}, N'(commit_cnt), N'(1));
    check({tag, "_shift_xfer"}, N'(overlap_cnt), N'(0));
    check({tag, "_commit_last"}, N'(commit_cyc > last_shift_cyc), N'(1));
    check({tag, "_state"}, cstate, pat);
    check({tag, "_stateen"}, N'(pin_stateen), N'(en));
`ifdef PUDDING_READBACK_EN
    check({tag, "_rb_data"}, rb_data, prev);
`endif
    model_state = pat;
  endtask

  initial begin
    logic [N-1:0] pa, pb;
    int d0, a0, w;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          N'({pin_datum, pin_shift, pin_transfer, pin_dir, pin_stateen, busy, done, bus.s_ready}),
          N'(8'b0000_0001));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Corner pattern: MSB and LSB set
    pa = '0; pa[N-1] = 1'b1; pa[0] = 1'b1;
    run_txn(pa, 1'b1, "corner");
    check("corner_uo_out", N'(uo_out), N'(8'h80));

    for (int i = 0; i < 4; i++) run_txn(rand_pat(), 1'($urandom()), "rand");

    // Back-to-back: hold s_valid across two patterns
    pa = '1;
    pb = {4{32'hA5A5_A5A5}};
    d0 = n_done; a0 = n_accepts;
    bus.s_data = pa; bus.s_enable = 1'b1; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_data = pb;
    w = 0;
    while (n_accepts < a0 + 2 && w < LAT + 20) begin @(posedge clk); #1; w++; end
    bus.s_valid = 1'b0;
    check("b2b_accepts", N'(n_accepts - a0), N'(2));
    check("b2b_ready_low", N'(last_ready_low), N'(LAT));
`ifdef PUDDING_READBACK_EN
    wait_done(d0 + 1, LAT + 20);
    check("b2b_rb_first", rb_data, model_state);
`endif
    wait_done(d0 + 2, 2 * LAT + 40);
    check("b2b_done_cnt", N'(n_done - d0), N'(2));
    check("b2b_state", cstate, pb);
`ifdef PUDDING_READBACK_EN
    check("b2b_rb_second", rb_data, pa);
`endif
    model_state = pb;
    @(posedge clk); #1;

    // Reset at bit 40 with committed state 0
    run_txn('0, 1'b1, "zero");
    d0 = n_done;
    bus.s_data = rand_pat(); bus.s_enable = 1'b1; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    w = 0;
    while (shift_cnt < 40 && w < LAT) begin @(posedge clk); #1; w++; end
    check("rst_reached_bit40", N'(shift_cnt), N'(40));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_pins",
          N'({pin_datum, pin_shift, pin_transfer, pin_dir, pin_stateen, busy, done, bus.s_ready}),
          N'(8'b0000_0001));
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", N'(n_done - d0), N'(0));
    check("rst_state_kept", cstate, '0);
    run_txn(rand_pat(), 1'b1, "after_rst");

    // stateen toggle and hold through idle
    run_txn(rand_pat(), 1'b0, "en0");
    repeat (20) @(posedge clk);
    #1;
    check("en0_hold", N'(pin_stateen), N'(0));
    run_txn(rand_pat(), 1'b1, "en1");
    repeat (20) @(posedge clk);
    #1;
    check("en1_hold", N'(pin_stateen), N'(1));
    check("stateen_only_on_accept", N'(stateen_bad), N'(0));

`ifdef PUDDING_READBACK_EN
    // Readback of a preloaded chip state
    preload_val = {2{64'h0123_4567_89AB_CDEF}};
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    model_state = preload_val;
    run_txn('0, 1'b1, "readback");
    check("rb_valid_with_done", N'(rb_mis), N'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
